// File: rtl/dpu_axi_apb_defs.sv
// Shared definitions for the DPU AXI4-Lite to APB3 CSR bridge:
// response codes, bridge FSM encoding and the APB slave slot map.
package dpu_axi_apb_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int SLOT_CONFIG = 0;
  localparam int SLOT_CONV   = 1;
  localparam int SLOT_POOL   = 2;
  localparam int SLOT_LINEAR = 3;
  localparam int SLOT_MOVER  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_t;

  // Bit width able to hold n distinct values, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpu_apb_decoder.sv
// Address decode for the bridge: picks the slave slot from the latched
// address and muxes that slot's PRDATA/PREADY/PSLVERR back to the FSM.
module dpu_apb_decoder
  import dpu_axi_apb_defs::*;
#(
  parameter int APB_WIDTH_AD = 32,
  parameter int APB_WIDTH_DA = 32,
  parameter int NUM_PSLV     = 5,
  parameter int PSLV_SHIFT   = 8,
  parameter int IDX_W        = width_of(NUM_PSLV)
) (
  input  logic [APB_WIDTH_AD-1:0]          addr,
  input  logic [NUM_PSLV*APB_WIDTH_DA-1:0] prdata_all,
  input  logic [NUM_PSLV-1:0]              pready_all,
  input  logic [NUM_PSLV-1:0]              pslverr_all,
  output logic                             hit,
  output logic [NUM_PSLV-1:0]              sel,
  output logic [APB_WIDTH_DA-1:0]          prdata,
  output logic                             pready,
  output logic                             pslverr
);

  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  assign idx         = addr[PSLV_SHIFT +: IDX_W];
  assign unused_addr = ^addr;

  // Indices past the last slot fall through with everything zero (decode error).
  always_comb begin
    hit     = 1'b0;
    sel     = '0;
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    for (int i = 0; i < NUM_PSLV; i++) begin
      if (idx == IDX_W'(i)) begin
        hit     = 1'b1;
        sel[i]  = 1'b1;
        prdata  = prdata_all[i*APB_WIDTH_DA +: APB_WIDTH_DA];
        pready  = pready_all[i];
        pslverr = pslverr_all[i];
      end
    end
  end

endmodule

// File: rtl/dpu_axi_lite2apb.sv
// AXI4-Lite slave to APB3 master bridge for the DPU CSR blocks; one
// transaction in flight, write/read arbitration alternates on contention.
//   state  | meaning
//   IDLE   | arbitrate AW+W vs AR, pulse READY, then launch on handshake
//   SETUP  | PSEL high, PENABLE low
//   ACCESS | PSEL and PENABLE high, wait for PREADY or timeout
//   RESP   | hold BVALID/RVALID until BREADY/RREADY
module dpu_axi_lite2apb
  import dpu_axi_apb_defs::*;
#(
  parameter int APB_WIDTH_AD = 32,
  parameter int APB_WIDTH_DA = 32,
  parameter int NUM_PSLV     = 5,
  parameter int PSLV_SHIFT   = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [APB_WIDTH_AD-1:0]          AWADDR,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [APB_WIDTH_DA-1:0]          WDATA,
  input  logic [APB_WIDTH_DA/8-1:0]        WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [APB_WIDTH_AD-1:0]          ARADDR,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [APB_WIDTH_DA-1:0]          RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [NUM_PSLV-1:0]              PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [APB_WIDTH_AD-1:0]          PADDR,
  output logic [APB_WIDTH_DA-1:0]          PWDATA,
  input  logic [NUM_PSLV*APB_WIDTH_DA-1:0] PRDATA,
  input  logic [NUM_PSLV-1:0]              PREADY,
  input  logic [NUM_PSLV-1:0]              PSLVERR
);

  localparam int TO_W = width_of(TIMEOUT + 1);

  bridge_state_t           state_q, state_d;
  logic                    wr_rdy_q, wr_rdy_d;
  logic                    ar_rdy_q, ar_rdy_d;
  logic                    last_wr_q, last_wr_d;
  logic [APB_WIDTH_AD-1:0] paddr_q, paddr_d;
  logic [APB_WIDTH_DA-1:0] pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [NUM_PSLV-1:0]     psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    bvalid_q, bvalid_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              resp_q, resp_d;
  logic [APB_WIDTH_DA-1:0] rdata_q, rdata_d;
  logic [TO_W-1:0]         wait_q, wait_d;

  logic                    dec_hit;
  logic [NUM_PSLV-1:0]     dec_sel;
  logic [APB_WIDTH_DA-1:0] dec_prdata;
  logic                    dec_pready;
  logic                    dec_pslverr;
  logic                    wr_elig, rd_elig;
  logic                    unused_wstrb;

  assign unused_wstrb = ^WSTRB;
  assign wr_elig      = AWVALID & WVALID;
  assign rd_elig      = ARVALID;

  dpu_apb_decoder #(
    .APB_WIDTH_AD (APB_WIDTH_AD),
    .APB_WIDTH_DA (APB_WIDTH_DA),
    .NUM_PSLV     (NUM_PSLV),
    .PSLV_SHIFT   (PSLV_SHIFT)
  ) u_decoder (
    .addr        (paddr_q),
    .prdata_all  (PRDATA),
    .pready_all  (PREADY),
    .pslverr_all (PSLVERR),
    .hit         (dec_hit),
    .sel         (dec_sel),
    .prdata      (dec_prdata),
    .pready      (dec_pready),
    .pslverr     (dec_pslverr)
  );

  always_comb begin
    state_d   = state_q;
    wr_rdy_d  = 1'b0;
    ar_rdy_d  = 1'b0;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    case (state_q)
      ST_IDLE: begin
        // Address/data are latched at grant; AXI keeps them stable until the
        // handshake, so the READY cycle can already decode the held copy.
        if (wr_rdy_q || ar_rdy_q) begin
          if (dec_hit) begin
            state_d   = ST_SETUP;
            psel_d    = dec_sel;
            penable_d = 1'b0;
            wait_d    = '0;
          end else begin
            state_d  = ST_RESP;
            resp_d   = RESP_DECERR;
            bvalid_d = pwrite_q;
            rvalid_d = !pwrite_q;
            if (!pwrite_q) rdata_d = '0;
          end
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          wr_rdy_d  = 1'b1;
          last_wr_d = 1'b1;
          paddr_d   = AWADDR;
          pwdata_d  = WDATA;
          pwrite_d  = 1'b1;
        end else if (rd_elig) begin
          ar_rdy_d  = 1'b1;
          last_wr_d = 1'b0;
          paddr_d   = ARADDR;
          pwrite_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (dec_pready) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          resp_d    = dec_pslverr ? RESP_SLVERR : RESP_OKAY;
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          if (!pwrite_q) rdata_d = dec_prdata;
        end else if (TIMEOUT != 0 && wait_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          resp_d    = RESP_SLVERR;
          bvalid_d  = pwrite_q;
          rvalid_d  = !pwrite_q;
          if (!pwrite_q) rdata_d = '0;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        if ((bvalid_q && BREADY) || (rvalid_q && RREADY)) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      wr_rdy_q  <= 1'b0;
      ar_rdy_q  <= 1'b0;
      last_wr_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_rdy_q  <= wr_rdy_d;
      ar_rdy_q  <= ar_rdy_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
    end
  end

  assign AWREADY = wr_rdy_q;
  assign WREADY  = wr_rdy_q;
  assign ARREADY = ar_rdy_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = resp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = resp_q;
  assign RDATA   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_dpu_axi_lite2apb.sv
// Bench for dpu_axi_lite2apb: directed scenarios with a response/APB
// scoreboard; the bridge is built with TIMEOUT=4.
module tb_dpu_axi_lite2apb;
  import dpu_axi_apb_defs::*;

  localparam int AD = 32;
  localparam int DA = 32;
  localparam int NS = 5;

  logic             PCLK, PRESETn;
  logic [AD-1:0]    AWADDR, ARADDR;
  logic             AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY;
  logic [DA-1:0]    WDATA, RDATA;
  logic [DA/8-1:0]  WSTRB;
  logic [1:0]       BRESP, RRESP;
  logic             BVALID, BREADY, RVALID, RREADY;
  logic [NS-1:0]    PSEL, PREADY, PSLVERR;
  logic             PENABLE, PWRITE;
  logic [AD-1:0]    PADDR;
  logic [DA-1:0]    PWDATA;
  logic [NS*DA-1:0] PRDATA;

  typedef struct {
    logic          is_wr;
    logic [1:0]    resp;
    logic [DA-1:0] rdata;
  } rsp_t;

  typedef struct {
    logic [NS-1:0] psel;
    logic          pwrite;
    logic [AD-1:0] paddr;
    logic [DA-1:0] pwdata;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  rsp_t mon_r;
  apb_t mon_a;
  int   checks = 0;
  int   errors = 0;

  dpu_axi_lite2apb #(
    .APB_WIDTH_AD (AD),
    .APB_WIDTH_DA (DA),
    .NUM_PSLV     (NS),
    .PSLV_SHIFT   (8),
    .TIMEOUT      (4)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn),
    .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
    .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
    .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE), .PADDR (PADDR),
    .PWDATA (PWDATA), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DA-1:0] slot_val(input int s);
    case (s)
      SLOT_CONFIG: return 32'h2025_0110;
      SLOT_CONV:   return 32'h1111_0001;
      SLOT_POOL:   return 32'h2222_0002;
      SLOT_LINEAR: return 32'h3333_0003;
      SLOT_MOVER:  return 32'h4444_0004;
      default:     return '0;
    endcase
  endfunction

  // Response scoreboard: B/R handshakes pop in order.
  always @(negedge PCLK) begin
    if (PRESETn && BVALID && BREADY) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: BRESP=%0b with no response expected", BRESP);
      end else begin
        mon_r = rsp_q.pop_front();
        if (mon_r.is_wr !== 1'b1 || BRESP !== mon_r.resp) begin
          errors++;
          $display("FAIL b_resp: got write BRESP=%0b, expected is_wr=%0b resp=%0b",
                   BRESP, mon_r.is_wr, mon_r.resp);
        end
      end
    end
    if (PRESETn && RVALID && RREADY) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: RRESP=%0b RDATA=%h with no response expected", RRESP, RDATA);
      end else begin
        mon_r = rsp_q.pop_front();
        if (mon_r.is_wr !== 1'b0 || RRESP !== mon_r.resp || RDATA !== mon_r.rdata) begin
          errors++;
          $display("FAIL r_resp: got RRESP=%0b RDATA=%h, expected is_wr=%0b resp=%0b rdata=%h",
                   RRESP, RDATA, mon_r.is_wr, mon_r.resp, mon_r.rdata);
        end
      end
    end
  end

  // APB scoreboard: completed transfers (selected PREADY in ACCESS) pop in order.
  always @(negedge PCLK) begin
    if (PRESETn && PSEL != '0 && PENABLE && |(PSEL & PREADY)) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: PSEL=%b PADDR=%h", PSEL, PADDR);
      end else begin
        mon_a = apb_q.pop_front();
        if (PSEL !== mon_a.psel || PWRITE !== mon_a.pwrite || PADDR !== mon_a.paddr ||
            (mon_a.pwrite && PWDATA !== mon_a.pwdata)) begin
          errors++;
          $display("FAIL apb_xfer: got PSEL=%b PWRITE=%b PADDR=%h PWDATA=%h, expected %b %b %h %h",
                   PSEL, PWRITE, PADDR, PWDATA, mon_a.psel, mon_a.pwrite, mon_a.paddr, mon_a.pwdata);
        end
      end
    end
  end

  task automatic exp_rsp(input logic is_wr, input logic [1:0] resp, input logic [DA-1:0] rdata);
    rsp_t r;
    r.is_wr = is_wr; r.resp = resp; r.rdata = rdata;
    rsp_q.push_back(r);
  endtask

  task automatic exp_apb(input logic [NS-1:0] psel, input logic pwrite, input logic [AD-1:0] paddr,
                         input logic [DA-1:0] pwdata);
    apb_t a;
    a.psel = psel; a.pwrite = pwrite; a.paddr = paddr; a.pwdata = pwdata;
    apb_q.push_back(a);
  endtask

  // Returns just after the posedge that ends the handshake cycle (T+1 begins).
  task automatic do_read(input logic [AD-1:0] addr);
    bit got = 1'b0;
    ARADDR = addr; ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (ARREADY) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL ar_handshake: ARREADY=%b, expected 1", ARREADY); end
    @(posedge PCLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic do_write(input logic [AD-1:0] addr, input logic [DA-1:0] data);
    bit got = 1'b0;
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (AWREADY) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || WREADY !== 1'b1) begin
      errors++;
      $display("FAIL aw_w_handshake: AWREADY=%b WREADY=%b, expected 1 1", AWREADY, WREADY);
    end
    @(posedge PCLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (rsp_q.size() == 0 && apb_q.size() == 0) break;
      @(negedge PCLK);
    end
    checks++;
    if (rsp_q.size() != 0 || apb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses and %0d APB transfers still pending, expected 0 0",
               rsp_q.size(), apb_q.size());
      rsp_q.delete(); apb_q.delete();
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '1; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    PREADY = '1; PSLVERR = '0;
    for (int s = 0; s < NS; s++) PRDATA[s*DA +: DA] = slot_val(s);
    @(negedge PCLK); @(negedge PCLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: ready/valid=%b, expected 00000",
                         {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if (PSEL !== '0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
      errors++; $display("FAIL reset_apb_ctrl: PSEL=%b PENABLE=%b PWRITE=%b, expected 0", PSEL, PENABLE, PWRITE);
    end
    checks++;
    if (PADDR !== '0 || PWDATA !== '0 || RDATA !== '0) begin
      errors++; $display("FAIL reset_data: PADDR=%h PWDATA=%h RDATA=%h, expected 0", PADDR, PWDATA, RDATA);
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00) begin
      errors++; $display("FAIL reset_resp: BRESP=%b RRESP=%b, expected 00", BRESP, RRESP);
    end
    #1 PRESETn = 1'b1;
  endtask

  task automatic test_read_basic();
    exp_apb(5'b00001, 1'b0, 32'h0000_0000, '0);
    exp_rsp(1'b0, RESP_OKAY, 32'h2025_0110);
    @(posedge PCLK); #1;
    do_read(32'h0000_0000);
    @(negedge PCLK);
    checks++;
    if (PSEL !== 5'b00001 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL read_setup: PSEL=%b PENABLE=%b, expected 00001 0", PSEL, PENABLE);
    end
    @(negedge PCLK);
    checks++;
    if (PSEL !== 5'b00001 || PENABLE !== 1'b1) begin
      errors++; $display("FAIL read_access: PSEL=%b PENABLE=%b, expected 00001 1", PSEL, PENABLE);
    end
    @(negedge PCLK);
    checks++;
    if (RVALID !== 1'b1 || PSEL !== '0) begin
      errors++; $display("FAIL read_latency: RVALID=%b PSEL=%b at T+3, expected 1 00000", RVALID, PSEL);
    end
    wait_drain();
  endtask

  task automatic test_write_aw_early();
    exp_apb(5'b00100, 1'b1, 32'h0000_0214, 32'hDEAD_BEEF);
    exp_rsp(1'b1, RESP_OKAY, '0);
    @(posedge PCLK); #1;
    AWADDR = 32'h0000_0214; AWVALID = 1'b1; WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      checks++;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++; $display("FAIL aw_alone: cycle %0d AWREADY=%b WREADY=%b, expected 0 0", k, AWREADY, WREADY);
      end
    end
    @(posedge PCLK); #1;
    do_write(32'h0000_0214, 32'hDEAD_BEEF);
    @(negedge PCLK);
    checks++;
    if (PSEL !== 5'b00100 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_setup: PSEL=%b PENABLE=%b PWRITE=%b PWDATA=%h, expected 00100 0 1 deadbeef",
                         PSEL, PENABLE, PWRITE, PWDATA);
    end
    wait_drain();
  endtask

  task automatic test_decode_error();
    exp_rsp(1'b0, RESP_DECERR, '0);
    @(posedge PCLK); #1;
    do_read(32'h0000_0700);
    @(negedge PCLK);
    checks++;
    if (RVALID !== 1'b1 || PSEL !== '0 || RDATA !== '0) begin
      errors++; $display("FAIL decerr_latency: RVALID=%b PSEL=%b RDATA=%h at T+1, expected 1 00000 0",
                         RVALID, PSEL, RDATA);
    end
    wait_drain();
  endtask

  task automatic test_arbitration();
    logic [AD-1:0] wa [2];
    logic [DA-1:0] wd [2];
    logic [AD-1:0] ra [2];
    logic          grant_wr [4];
    int            wi = 0, ri = 0, ng = 0;
    logic          gw, gr;
    wa[0] = 32'h0000_0300; wd[0] = 32'hA5A5_0001; ra[0] = 32'h0000_0000;
    wa[1] = 32'h0000_0400; wd[1] = 32'hA5A5_0002; ra[1] = 32'h0000_0100;
    for (int k = 0; k < 4; k++) grant_wr[k] = 1'bx;
    PSLVERR = 5'b01000;
    exp_apb(5'b01000, 1'b1, wa[0], wd[0]); exp_rsp(1'b1, RESP_SLVERR, '0);
    exp_apb(5'b00001, 1'b0, ra[0], '0);    exp_rsp(1'b0, RESP_OKAY, slot_val(SLOT_CONFIG));
    exp_apb(5'b10000, 1'b1, wa[1], wd[1]); exp_rsp(1'b1, RESP_OKAY, '0);
    exp_apb(5'b00010, 1'b0, ra[1], '0);    exp_rsp(1'b0, RESP_OKAY, slot_val(SLOT_CONV));
    @(posedge PCLK); #1;
    AWADDR = wa[0]; WDATA = wd[0]; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = ra[0]; ARVALID = 1'b1;
    for (int c = 0; c < 100 && (wi < 2 || ri < 2); c++) begin
      @(negedge PCLK);
      gw = AWREADY; gr = ARREADY;
      if (gw || gr) begin
        if (ng < 4) grant_wr[ng] = gw;
        ng++;
      end
      @(posedge PCLK); #1;
      if (gw) begin
        wi++;
        if (wi < 2) begin AWADDR = wa[wi]; WDATA = wd[wi]; end
        else begin AWVALID = 1'b0; WVALID = 1'b0; end
      end
      if (gr) begin
        ri++;
        if (ri < 2) ARADDR = ra[ri];
        else ARVALID = 1'b0;
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (ng != 4) begin errors++; $display("FAIL grant_count: got %0d grants, expected 4", ng); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant_wr[k] !== ((k % 2) == 0)) begin
        errors++; $display("FAIL grant_order: grant %0d is_write=%b, expected %b", k, grant_wr[k], (k % 2) == 0);
      end
    end
    wait_drain();
    PSLVERR = '0;
  endtask

  task automatic test_timeout();
    int acc = 0;
    bit seen = 1'b0;
    PREADY[SLOT_CONV] = 1'b0;
    RREADY = 1'b0;
    exp_rsp(1'b0, RESP_SLVERR, '0);
    @(posedge PCLK); #1;
    do_read(32'h0000_0104);
    for (int i = 0; i < 15; i++) begin
      @(negedge PCLK);
      if (RVALID) begin seen = 1'b1; break; end
      if (PSEL[SLOT_CONV] && PENABLE) acc++;
    end
    checks++;
    if (!seen || acc != 4) begin
      errors++; $display("FAIL timeout_cycles: RVALID seen=%b ACCESS cycles=%0d, expected 1 and 4", seen, acc);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== '0 || RRESP !== RESP_SLVERR || PSEL !== '0) begin
        errors++; $display("FAIL timeout_hold: cycle %0d RVALID=%b RDATA=%h RRESP=%b PSEL=%b, expected 1 0 10 00000",
                           k, RVALID, RDATA, RRESP, PSEL);
      end
      @(negedge PCLK);
    end
    @(posedge PCLK); #1;
    RREADY = 1'b1;
    wait_drain();
    PREADY = '1;
  endtask

  task automatic test_reset_mid();
    bit in_access = 1'b0;
    PREADY[SLOT_POOL] = 1'b0;
    @(posedge PCLK); #1;
    do_read(32'h0000_0208);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (PENABLE) begin in_access = 1'b1; break; end
    end
    checks++;
    if (!in_access) begin errors++; $display("FAIL reset_mid_access: PENABLE=%b, expected 1", PENABLE); end
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if (PSEL !== '0 || PENABLE !== 1'b0 || RVALID !== 1'b0 || BVALID !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abort: PSEL=%b PENABLE=%b RVALID=%b BVALID=%b, expected all 0",
                         PSEL, PENABLE, RVALID, BVALID);
    end
    PREADY = '1;
    @(negedge PCLK); @(negedge PCLK);
    #1 PRESETn = 1'b1;
    exp_apb(5'b00100, 1'b0, 32'h0000_0208, '0);
    exp_rsp(1'b0, RESP_OKAY, slot_val(SLOT_POOL));
    @(posedge PCLK); #1;
    do_read(32'h0000_0208);
    wait_drain();
    checks++;
    if (RDATA !== slot_val(SLOT_POOL)) begin
      errors++; $display("FAIL reset_mid_recover: RDATA=%h, expected %h", RDATA, slot_val(SLOT_POOL));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_aw_early();
    test_decode_error();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
